// File: rtl/pattern_match_sequencer_if.sv
// Control/stream bundle between the host, the serial line and the pattern match sequencer.
// Signal prefixes are from the sequencer's point of view: i_ into it, o_ out of it.
interface pattern_match_sequencer_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TO_W  = 16
);
    logic             i_start;
    logic [PAT_W-1:0] i_pattern;
    logic [CNT_W-1:0] i_target_cnt;
    logic [TO_W-1:0]  i_timeout;
    logic             i_abort;
    logic             i_in;
    logic             i_in_valid;
    logic             o_busy;
    logic             o_match_pulse;
    logic [CNT_W-1:0] o_match_cnt;
    logic             o_done;
    logic [1:0]       o_status;

    modport master (
        output i_start, i_pattern, i_target_cnt, i_timeout, i_abort, i_in, i_in_valid,
        input  o_busy, o_match_pulse, o_match_cnt, o_done, o_status
    );

    modport slave (
        input  i_start, i_pattern, i_target_cnt, i_timeout, i_abort, i_in, i_in_valid,
        output o_busy, o_match_pulse, o_match_cnt, o_done, o_status
    );
endinterface

// File: rtl/pattern_match_sequencer.sv
// Run controller for the serial bit-pattern detector: counts overlapping matches
// until the target is hit, the timeout expires or the host aborts, then reports done.
module pattern_match_sequencer #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TO_W  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    pattern_match_sequencer_if.slave       bus
);
    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_HIT   = 2'b01;
    localparam logic [1:0] ST_TO    = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_status, w_status_nxt;
    logic [PAT_W-2:0] r_shreg;
    logic [FILL_W-1:0] r_fill;
    logic [CNT_W-1:0] r_match_cnt;
    logic [TO_W-1:0]  r_cyc_cnt;
    logic [PAT_W-1:0] r_pat;
    logic [CNT_W-1:0] r_tgt;
    logic [TO_W-1:0]  r_to;

    logic             w_run;
    logic             w_accept;
    logic [PAT_W-1:0] w_window;
    logic             w_match;
    logic             w_last_hit;
    logic             w_timeout;

    assign w_run    = (r_state == S_RUN);
    assign w_accept = (r_state == S_IDLE) && bus.i_start;
    assign w_window = {r_shreg, bus.i_in};

    // Abort suppresses the pulse so a concurrent match never bumps the count.
    assign w_match = w_run && bus.i_in_valid && (r_fill == FILL_MAX) &&
                     (w_window == r_pat) && !bus.i_abort;

    // Compare one bit wider so a full counter cannot alias onto a small target.
    assign w_last_hit = w_match &&
                        (({1'b0, r_match_cnt} + (CNT_W+1)'(1)) == {1'b0, r_tgt});
    assign w_timeout  = (r_to != '0) && (r_cyc_cnt == r_to - TO_W'(1));

    always_comb begin
        w_state_nxt  = r_state;
        w_status_nxt = r_status;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_target_cnt == '0) begin
                        w_state_nxt  = S_DONE;
                        w_status_nxt = ST_HIT;
                    end else begin
                        w_state_nxt  = S_RUN;
                        w_status_nxt = ST_NONE;
                    end
                end
            end
            S_RUN: begin
                if (bus.i_abort) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_ABORT;
                end else if (w_last_hit) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_HIT;
                end else if (w_timeout) begin
                    w_state_nxt  = S_DONE;
                    w_status_nxt = ST_TO;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_status    <= ST_NONE;
            r_shreg     <= '0;
            r_fill      <= '0;
            r_match_cnt <= '0;
            r_cyc_cnt   <= '0;
            r_pat       <= '0;
            r_tgt       <= '0;
            r_to        <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_status <= w_status_nxt;
            if (w_accept) begin
                r_pat       <= bus.i_pattern;
                r_tgt       <= bus.i_target_cnt;
                r_to        <= bus.i_timeout;
                r_shreg     <= '0;
                r_fill      <= '0;
                r_cyc_cnt   <= '0;
                r_match_cnt <= '0;
            end
            if (w_run) begin
                r_cyc_cnt <= r_cyc_cnt + TO_W'(1);
                // The shift history survives a match, which is what lets matches overlap.
                if (bus.i_in_valid) begin
                    r_shreg <= w_window[PAT_W-2:0];
                    if (r_fill != FILL_MAX)
                        r_fill <= r_fill + FILL_W'(1);
                end
                if (w_match)
                    r_match_cnt <= r_match_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.o_busy        = w_run;
    assign bus.o_match_pulse = w_match;
    assign bus.o_match_cnt   = r_match_cnt;
    assign bus.o_done        = (r_state == S_DONE);
    assign bus.o_status      = r_status;
endmodule
